// File: rtl/adc_display_pkg.sv
// Shared constants, scan FSM states and bar-level helpers for the ADC bar display.
package adc_display_pkg;

    localparam int NUM_COLS    = 4;
    localparam int NUM_ROWS    = 8;
    localparam int LEVEL_W     = 4;
    localparam int VALUE_W     = 10;
    localparam int ROUND_CONST = 64;
    localparam int LEVEL_SHIFT = 7;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_SHOW  = 1'b1
    } scan_state_t;

    // Bars [level-1:0] lit; level 0 lights nothing, level 8 lights all rows.
    function automatic logic [NUM_ROWS-1:0] thermometer(input logic [LEVEL_W-1:0] level);
        logic [NUM_ROWS-1:0] bars;
        bars = '0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            if (LEVEL_W'(i) < level) begin
                bars[i] = 1'b1;
            end
        end
        return bars;
    endfunction

    // Round-to-nearest bar step: (value + 64) >> 7 in 11 bits, range 0..8.
    function automatic logic [LEVEL_W-1:0] level_of(input logic [VALUE_W-1:0] value);
        logic [VALUE_W:0] sum;
        sum = {1'b0, value} + (VALUE_W + 1)'(ROUND_CONST);
        return sum[VALUE_W:LEVEL_SHIFT];
    endfunction

endpackage

// File: rtl/adc_bar_display_if.sv
// Measurement inputs and LED matrix drive of the bar display.
interface adc_bar_display_if;
    import adc_display_pkg::*;

    logic [VALUE_W-1:0]  value1;
    logic [VALUE_W-1:0]  value2;
    logic [VALUE_W-1:0]  value3;
    logic [VALUE_W-1:0]  value4;
    logic [NUM_ROWS-1:0] ledRowN;
    logic [NUM_COLS-1:0] ledColN;
    logic                frameTick;

    modport master (
        output value1, value2, value3, value4,
        input  ledRowN, ledColN, frameTick
    );

    modport slave (
        input  value1, value2, value3, value4,
        output ledRowN, ledColN, frameTick
    );

endinterface

// File: rtl/adc_bar_display_peak_tracker.sv
// Per-channel peak-hold register with frame-based one-step decay.
module adc_peak_tracker
    import adc_display_pkg::*;
#(
    parameter int PEAK_DECAY_FRAMES = 250
)(
    input  logic               clock12MHz,
    input  logic               resetN,
    input  logic [LEVEL_W-1:0] level,
    input  logic               sampleStrobe,
    input  logic               frameTick,
    output logic [LEVEL_W-1:0] peak
);

    localparam int CNT_W = $clog2(PEAK_DECAY_FRAMES + 1);
    localparam logic [CNT_W-1:0] DECAY_LAST = CNT_W'(PEAK_DECAY_FRAMES - 1);

    logic [CNT_W-1:0]   decayCount;
    logic [LEVEL_W-1:0] heldLevel;

    // Capture new peaks at the sampling strobe; otherwise step the decay on each frame.
    always_ff @(posedge clock12MHz or negedge resetN) begin
        if (!resetN) begin
            peak       <= '0;
            heldLevel  <= '0;
            decayCount <= '0;
        end else if (sampleStrobe) begin
            heldLevel <= level;
            if (level > peak) begin
                peak       <= level;
                decayCount <= '0;
            end
        end else if (frameTick) begin
            if (decayCount == DECAY_LAST) begin
                decayCount <= '0;
                if (peak > heldLevel) begin
                    peak <= peak - LEVEL_W'(1);
                end
            end else begin
                decayCount <= decayCount + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/adc_bar_display.sv
// Four-channel ADC bar display: column-scanned 8x4 LED matrix with per-slot blanking.
// Optional peak-hold dots are enabled by defining ADC_BAR_PEAK_HOLD_EN.
module adc_bar_display
    import adc_display_pkg::*;
#(
    parameter int TICKS_PER_COLUMN  = 3000,
    parameter int DEAD_TICKS        = 16,
    parameter int PEAK_DECAY_FRAMES = 250
)(
    input  logic             clock12MHz,
    input  logic             resetN,
    adc_bar_display_if.slave bus
);

    localparam int TICK_W = $clog2(TICKS_PER_COLUMN);
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(TICKS_PER_COLUMN - 1);
    localparam logic [TICK_W-1:0] DEAD_LAST = TICK_W'(DEAD_TICKS - 1);

    if (TICKS_PER_COLUMN <= DEAD_TICKS || DEAD_TICKS < 1 || PEAK_DECAY_FRAMES < 1) begin : gBadParams
        $error("adc_bar_display: invalid scan timing parameters");
    end

    scan_state_t         state, stateNext;
    logic [TICK_W-1:0]   tickCount, tickNext;
    logic [1:0]          column, columnNext;
    logic [LEVEL_W-1:0]  level, levelNext;
    logic [VALUE_W-1:0]  curValue;
    logic                lastTick, sampleNow;
    logic [NUM_ROWS-1:0] rowNextN, peakDot;
    logic [NUM_COLS-1:0] colNextN;
    logic                frameNext;

    // Scan state register: FSM state, slot tick, active column and latched level.
    always_ff @(posedge clock12MHz or negedge resetN) begin
        if (!resetN) begin
            state     <= S_BLANK;
            tickCount <= '0;
            column    <= '0;
            level     <= '0;
        end else begin
            state     <= stateNext;
            tickCount <= tickNext;
            column    <= columnNext;
            level     <= levelNext;
        end
    end

    // Select the measurement belonging to the column being scanned.
    always_comb begin
        curValue = bus.value1;
        case (column)
            2'd0:    curValue = bus.value1;
            2'd1:    curValue = bus.value2;
            2'd2:    curValue = bus.value3;
            default: curValue = bus.value4;
        endcase
    end

    // Next-state logic: slot timing, column advance and the single sampling point.
    always_comb begin
        lastTick   = (tickCount == LAST_TICK);
        sampleNow  = (state == S_BLANK) && (tickCount == DEAD_LAST);
        tickNext   = lastTick ? '0 : tickCount + TICK_W'(1);
        columnNext = lastTick ? column + 2'd1 : column;
        levelNext  = sampleNow ? level_of(curValue) : level;
        stateNext  = state;
        case (state)
            S_BLANK: if (sampleNow) stateNext = S_SHOW;
            S_SHOW:  if (lastTick)  stateNext = S_BLANK;
            default: stateNext = S_BLANK;
        endcase
    end

`ifdef ADC_BAR_PEAK_HOLD_EN
    logic [LEVEL_W-1:0] peak [NUM_COLS];
    logic [LEVEL_W-1:0] shownPeak;

    for (genvar ch = 0; ch < NUM_COLS; ch++) begin : gPeak
        adc_peak_tracker #(
            .PEAK_DECAY_FRAMES(PEAK_DECAY_FRAMES)
        ) uPeak (
            .clock12MHz  (clock12MHz),
            .resetN      (resetN),
            .level       (levelNext),
            .sampleStrobe(sampleNow && (column == 2'(ch))),
            .frameTick   (bus.frameTick),
            .peak        (peak[ch])
        );
    end

    // Peak dot for the column about to be shown; a fresh sample above the stored peak wins.
    always_comb begin
        shownPeak = (levelNext > peak[columnNext]) ? levelNext : peak[columnNext];
        peakDot   = '0;
        if (shownPeak != '0) begin
            peakDot = NUM_ROWS'(1) << (shownPeak - LEVEL_W'(1));
        end
    end
`else
    // Plain thermometer display: no peak dot.
    always_comb begin
        peakDot = '0;
    end
`endif

    // Output decode from next-state values so rows and column enables land on the same edge.
    always_comb begin
        rowNextN  = '1;
        colNextN  = '1;
        frameNext = (tickNext == LAST_TICK) && (columnNext == 2'd3);
        if (stateNext == S_SHOW) begin
            colNextN = ~(4'b0001 << columnNext);
            rowNextN = ~(thermometer(levelNext) | peakDot);
        end
    end

    // Output registers; reset blanks the matrix immediately.
    always_ff @(posedge clock12MHz or negedge resetN) begin
        if (!resetN) begin
            bus.ledRowN   <= '1;
            bus.ledColN   <= '1;
            bus.frameTick <= 1'b0;
        end else begin
            bus.ledRowN   <= rowNextN;
            bus.ledColN   <= colNextN;
            bus.frameTick <= frameNext;
        end
    end

endmodule

// File: tb/tb_adc_bar_display.sv
// Randomized self-checking bench for adc_bar_display against a frame-level scan model.
module tb_adc_bar_display;

    localparam int TPC   = 64;
    localparam int DEAD  = 5;
    localparam int PDF   = 2;
    localparam int FRAME = 4 * TPC;

    logic clk = 1'b0;
    logic resetN = 1'b1;

    always #5 clk = ~clk;

    adc_bar_display_if bus();

    adc_bar_display #(
        .TICKS_PER_COLUMN (TPC),
        .DEAD_TICKS       (DEAD),
        .PEAK_DECAY_FRAMES(PDF)
    ) dut (
        .clock12MHz(clk),
        .resetN    (resetN),
        .bus       (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model state: cycles since reset release, sampled level and peak bookkeeping per channel.
    int cyc;
    int smp [4];
    int pk  [4];
    int pc  [4];
    int hl  [4];
    logic [7:0] exp_row;
    logic [3:0] exp_col;
    logic       exp_ft;

    function automatic int getv(input int c);
        case (c)
            0:       return int'(bus.value1);
            1:       return int'(bus.value2);
            2:       return int'(bus.value3);
            default: return int'(bus.value4);
        endcase
    endfunction

    function automatic int lvl_of(input int v);
        return (v + 64) / 128;
    endfunction

    task automatic model_reset();
        cyc = 0;
        for (int c = 0; c < 4; c++) begin
            smp[c] = 0; pk[c] = 0; pc[c] = 0; hl[c] = 0;
        end
        exp_row = 8'hFF; exp_col = 4'hF; exp_ft = 1'b0;
    endtask

    // Apply the model's edge effects for the current cycle, advance one cycle, compute expectations.
    task automatic step();
        int t, tick, col, l;
        logic [7:0] thermo, dot;
        t = cyc % FRAME; tick = t % TPC; col = t / TPC;
        if (tick == DEAD - 1) begin
            l = lvl_of(getv(col));
            smp[col] = l;
            hl[col]  = l;
            if (l > pk[col]) begin
                pk[col] = l;
                pc[col] = 0;
            end
        end
        if (t == FRAME - 1) begin
            for (int c = 0; c < 4; c++) begin
                pc[c]++;
                if (pc[c] == PDF) begin
                    pc[c] = 0;
                    if (pk[c] > hl[c]) pk[c]--;
                end
            end
        end
        @(negedge clk);
        cyc++;
        t = cyc % FRAME; tick = t % TPC; col = t / TPC;
        thermo = 8'((1 << smp[col]) - 1);
        dot = 8'h00;
`ifdef ADC_BAR_PEAK_HOLD_EN
        if (pk[col] > 0) dot = 8'(1 << (pk[col] - 1));
`endif
        exp_ft = (t == FRAME - 1);
        if (tick < DEAD) begin
            exp_row = 8'hFF;
            exp_col = 4'hF;
        end else begin
            exp_row = ~(thermo | dot);
            exp_col = ~(4'b0001 << col);
        end
    endtask

    task automatic set_all(input int v1, input int v2, input int v3, input int v4);
        bus.value1 = 10'(v1); bus.value2 = 10'(v2); bus.value3 = 10'(v3); bus.value4 = 10'(v4);
    endtask

    task automatic test_reset();
        bit found;
        #2 resetN = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++;
            if ({bus.ledRowN, bus.ledColN, bus.frameTick} !== {8'hFF, 4'hF, 1'b0}) begin
                miscompares++;
                $display("FAIL reset_hold: got row=%h col=%h ft=%b, need row=ff col=f ft=0",
                         bus.ledRowN, bus.ledColN, bus.frameTick);
            end
        end
        resetN = 1'b1;
        model_reset();
        found = 1'b0;
        for (int i = 0; i < 2 * TPC && !found; i++) begin
            step();
            vectors++;
            if ({bus.ledRowN, bus.ledColN, bus.frameTick} !== {exp_row, exp_col, exp_ft}) begin
                miscompares++;
                $display("FAIL reset_scan cyc=%0d: got %h/%h/%b, need %h/%h/%b",
                         cyc, bus.ledRowN, bus.ledColN, bus.frameTick, exp_row, exp_col, exp_ft);
            end
            if (bus.ledColN !== 4'hF) found = 1'b1;
        end
        vectors++;
        if (!found || cyc != DEAD || bus.ledColN !== 4'hE) begin
            miscompares++;
            $display("FAIL first_enable: got cycle %0d col=%h, need cycle %0d col=e", cyc, bus.ledColN, DEAD);
        end
    endtask

    task automatic test_level_mapping();
        int codes [6] = '{0, 63, 64, 959, 960, 1023};
        logic [7:0] rows [6] = '{8'hFF, 8'hFF, 8'hFE, 8'h80, 8'h00, 8'h00};
        for (int k = 0; k < 6; k++) begin
            while (cyc % FRAME != 0) begin
                step();
                vectors++;
                if ({bus.ledRowN, bus.ledColN, bus.frameTick} !== {exp_row, exp_col, exp_ft}) begin
                    miscompares++;
                    $display("FAIL map_scan cyc=%0d: got %h/%h/%b, need %h/%h/%b",
                             cyc, bus.ledRowN, bus.ledColN, bus.frameTick, exp_row, exp_col, exp_ft);
                end
            end
            bus.value1 = 10'(codes[k]);
            for (int i = 0; i < TPC / 2; i++) step();
            vectors++;
            if (bus.ledColN !== 4'hE || bus.ledRowN !== rows[k]) begin
                miscompares++;
                $display("FAIL level_map code=%0d: got row=%h col=%h, need row=%h col=e",
                         codes[k], bus.ledRowN, bus.ledColN, rows[k]);
            end
        end
    endtask

    task automatic test_scan_timing();
        int en [4];
        int ft, blank;
        logic [7:0] mid [4];
        logic [7:0] need [4] = '{8'hFE, 8'hF8, 8'hE0, 8'h00};
        while (cyc % FRAME != 0) step();
        set_all(128, 384, 640, 1023);
        for (int c = 0; c < 4; c++) en[c] = 0;
        ft = 0; blank = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            vectors++;
            if ({bus.ledRowN, bus.ledColN, bus.frameTick} !== {exp_row, exp_col, exp_ft}) begin
                miscompares++;
                $display("FAIL scan cyc=%0d: got %h/%h/%b, need %h/%h/%b",
                         cyc, bus.ledRowN, bus.ledColN, bus.frameTick, exp_row, exp_col, exp_ft);
            end
            if (i >= FRAME) begin
                for (int c = 0; c < 4; c++) if (bus.ledColN === ~(4'b0001 << c)) en[c]++;
                if (bus.ledColN === 4'hF) blank++;
                if (bus.frameTick === 1'b1) ft++;
                if ((cyc % TPC) == TPC / 2) mid[(cyc % FRAME) / TPC] = bus.ledRowN;
            end
        end
        for (int c = 0; c < 4; c++) begin
            vectors++;
            if (en[c] != TPC - DEAD || mid[c] !== need[c]) begin
                miscompares++;
                $display("FAIL column_%0d: got %0d enabled cycles row=%h, need %0d row=%h",
                         c, en[c], mid[c], TPC - DEAD, need[c]);
            end
        end
        vectors++;
        if (ft != 1 || blank != 4 * DEAD) begin
            miscompares++;
            $display("FAIL frame_timing: got %0d frameTicks %0d blank cycles, need 1 and %0d", ft, blank, 4 * DEAD);
        end
    endtask

    task automatic test_mid_slot_change();
        while (cyc % FRAME != 0) step();
        set_all(300, 0, 500, 700);
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            if ((cyc % FRAME) == TPC + DEAD + (TPC - DEAD) / 2 && i < FRAME) bus.value2 = 10'd1023;
            vectors++;
            if ({bus.ledRowN, bus.ledColN, bus.frameTick} !== {exp_row, exp_col, exp_ft}) begin
                miscompares++;
                $display("FAIL mid_scan cyc=%0d: got %h/%h/%b, need %h/%h/%b",
                         cyc, bus.ledRowN, bus.ledColN, bus.frameTick, exp_row, exp_col, exp_ft);
            end
            if ((cyc % FRAME) == 2 * TPC - 1) begin
                vectors++;
                if (bus.ledColN !== 4'hD || bus.ledRowN !== ((i < FRAME) ? 8'hFF : 8'h00)) begin
                    miscompares++;
                    $display("FAIL mid_slot frame=%0d: got row=%h col=%h, need row=%h col=d",
                             i / FRAME, bus.ledRowN, bus.ledColN, (i < FRAME) ? 8'hFF : 8'h00);
                end
            end
        end
    endtask

    task automatic test_random();
        int ch;
        int edges [6] = '{0, 63, 64, 191, 192, 1023};
        for (int i = 0; i < 8 * FRAME; i++) begin
            step();
            vectors++;
            if ({bus.ledRowN, bus.ledColN, bus.frameTick} !== {exp_row, exp_col, exp_ft}) begin
                miscompares++;
                $display("FAIL random cyc=%0d: got %h/%h/%b, need %h/%h/%b",
                         cyc, bus.ledRowN, bus.ledColN, bus.frameTick, exp_row, exp_col, exp_ft);
            end
            if ($urandom_range(0, 7) == 0) begin
                ch = int'($urandom_range(0, 3));
                case (ch)
                    0: bus.value1 = ($urandom_range(0, 1)) ? 10'($urandom_range(0, 1023)) : 10'(edges[$urandom_range(0, 5)]);
                    1: bus.value2 = 10'($urandom_range(0, 1023));
                    2: bus.value3 = ($urandom_range(0, 1)) ? 10'($urandom_range(0, 1023)) : 10'(edges[$urandom_range(0, 5)]);
                    default: bus.value4 = 10'($urandom_range(0, 1023));
                endcase
            end
        end
    endtask

    task automatic test_async_reset();
        while ((cyc % FRAME) != 2 * TPC + TPC / 2) step();
        set_all(1023, 1023, 1023, 1023);
        #2 resetN = 1'b0;
        #1;
        vectors++;
        if ({bus.ledRowN, bus.ledColN, bus.frameTick} !== {8'hFF, 4'hF, 1'b0}) begin
            miscompares++;
            $display("FAIL async_reset: got row=%h col=%h ft=%b before next edge, need ff/f/0",
                     bus.ledRowN, bus.ledColN, bus.frameTick);
        end
        @(negedge clk);
        @(negedge clk);
        resetN = 1'b1;
        model_reset();
        for (int i = 0; i < FRAME + TPC; i++) begin
            step();
            vectors++;
            if ({bus.ledRowN, bus.ledColN, bus.frameTick} !== {exp_row, exp_col, exp_ft}) begin
                miscompares++;
                $display("FAIL restart cyc=%0d: got %h/%h/%b, need %h/%h/%b",
                         cyc, bus.ledRowN, bus.ledColN, bus.frameTick, exp_row, exp_col, exp_ft);
            end
        end
    endtask

`ifdef ADC_BAR_PEAK_HOLD_EN
    task automatic test_peak_hold();
        logic [7:0] need [6] = '{8'h00, 8'h7F, 8'hBF, 8'hBF, 8'hDF, 8'hDF};
        set_all(0, 0, 0, 0);
        @(negedge clk);
        resetN = 1'b0;
        @(negedge clk);
        resetN = 1'b1;
        model_reset();
        bus.value1 = 10'd1023;
        for (int f = 0; f < 6; f++) begin
            if (f == 1) bus.value1 = 10'd0;
            for (int i = 0; i < FRAME; i++) begin
                step();
                vectors++;
                if ({bus.ledRowN, bus.ledColN, bus.frameTick} !== {exp_row, exp_col, exp_ft}) begin
                    miscompares++;
                    $display("FAIL peak_scan cyc=%0d: got %h/%h/%b, need %h/%h/%b",
                             cyc, bus.ledRowN, bus.ledColN, bus.frameTick, exp_row, exp_col, exp_ft);
                end
                if ((cyc % FRAME) == TPC / 2) begin
                    vectors++;
                    if (bus.ledRowN !== need[f]) begin
                        miscompares++;
                        $display("FAIL peak_frame_%0d: got row=%h, need %h", f, bus.ledRowN, need[f]);
                    end
                end
            end
        end
    endtask
`endif

    initial begin
        set_all(0, 0, 0, 0);
        model_reset();
        test_reset();
        test_level_mapping();
        test_scan_timing();
        test_mid_slot_change();
        test_random();
        test_async_reset();
`ifdef ADC_BAR_PEAK_HOLD_EN
        test_peak_hold();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
